// File: rtl/sched_pkg.sv
// Shared scheduler types: task index, period and the release request
// bundle handed from the release generator to the scheduler core.
package sched_pkg;

    localparam int NUM_TASKS = 4;
    localparam int PERIOD_W  = 16;
    localparam int ID_W      = $clog2(NUM_TASKS);

    typedef logic [ID_W-1:0]     task_id_t;
    typedef logic [PERIOD_W-1:0] period_t;

    typedef struct packed {
        logic     valid;
        task_id_t id;
    } rel_req_t;

endpackage

// File: rtl/task_timer.sv
// Per-task period timer: holds the period register and counter, and
// strobes evt for one cycle each time the period elapses.
module task_timer #(
    parameter int PERIOD_W = sched_pkg::PERIOD_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                cfg_we,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic                evt
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] period_q, period_d;

    always_comb begin
        cnt_d    = cnt_q;
        period_d = period_q;
        evt      = 1'b0;
        // a write restarts the timer and swallows this cycle's event
        if (cfg_we) begin
            period_d = cfg_period;
            cnt_d    = '0;
        end else if (en && (period_q != '0)) begin
            if (cnt_q == period_q - 1'b1) begin
                cnt_d = '0;
                evt   = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q    <= '0;
            period_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            period_q <= period_d;
        end
    end

endmodule

// File: rtl/task_release_gen.sv
// Periodic job-release generator: one timer per task, pending bits,
// a single-entry output slot with fixed priority and overrun flags.
module task_release_gen #(
    parameter int NUM_TASKS = sched_pkg::NUM_TASKS,
    parameter int PERIOD_W  = sched_pkg::PERIOD_W,
    parameter int ID_W      = $clog2(NUM_TASKS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 cfg_we,
    input  logic [ID_W-1:0]      cfg_id,
    input  logic [PERIOD_W-1:0]  cfg_period,
    output logic                 rel_valid,
    output logic [ID_W-1:0]      rel_id,
    input  logic                 rel_ready,
    output logic [NUM_TASKS-1:0] overrun,
    input  logic                 overrun_clr
);

    logic [NUM_TASKS-1:0] evt;
    logic [NUM_TASKS-1:0] pending_q, pending_d;
    logic [NUM_TASKS-1:0] ovr_q, ovr_d;
    logic                 slot_valid_q, slot_valid_d;
    logic [ID_W-1:0]      slot_id_q, slot_id_d;
    logic [ID_W-1:0]      sel_id;
    logic                 any_pend;
    logic                 slot_free;
    logic                 load;

    for (genvar gi = 0; gi < NUM_TASKS; gi++) begin : g_timer
        task_timer #(
            .PERIOD_W (PERIOD_W)
        ) u_timer (
            .clk        (clk),
            .rst        (rst),
            .en         (en),
            .cfg_we     (cfg_we && (cfg_id == ID_W'(gi))),
            .cfg_period (cfg_period),
            .evt        (evt[gi])
        );
    end

    // lowest pending index wins (rate-monotonic order)
    always_comb begin
        sel_id   = '0;
        any_pend = 1'b0;
        for (int i = NUM_TASKS - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_id   = ID_W'(i);
                any_pend = 1'b1;
            end
        end
    end

    always_comb begin
        slot_free    = !slot_valid_q || rel_ready;
        load         = slot_free && any_pend;
        slot_valid_d = slot_valid_q;
        slot_id_d    = slot_id_q;
        if (slot_free) begin
            slot_valid_d = any_pend;
            if (any_pend) begin
                slot_id_d = sel_id;
            end
        end
    end

    always_comb begin
        pending_d = pending_q;
        ovr_d     = overrun_clr ? '0 : ovr_q;
        for (int i = 0; i < NUM_TASKS; i++) begin
            if (load && (sel_id == ID_W'(i))) begin
                pending_d[i] = 1'b0;
            end
            // a refill while the old release moves to the slot is no overrun
            if (evt[i]) begin
                pending_d[i] = 1'b1;
                if (pending_q[i] && !(load && (sel_id == ID_W'(i)))) begin
                    ovr_d[i] = 1'b1;
                end
            end
            if (cfg_we && (cfg_id == ID_W'(i))) begin
                pending_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending_q    <= '0;
            ovr_q        <= '0;
            slot_valid_q <= 1'b0;
            slot_id_q    <= '0;
        end else begin
            pending_q    <= pending_d;
            ovr_q        <= ovr_d;
            slot_valid_q <= slot_valid_d;
            slot_id_q    <= slot_id_d;
        end
    end

    assign rel_valid = slot_valid_q;
    assign rel_id    = slot_id_q;
    assign overrun   = ovr_q;

endmodule

// File: tb/tb_task_release_gen.sv
// Directed bench for task_release_gen: single task, priority, stall
// with overrun, freeze/disable and asynchronous reset mid-handshake.
module tb_task_release_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_id = '0;
    logic [15:0] cfg_period = '0;
    logic        rel_ready = 1'b0;
    logic        overrun_clr = 1'b0;
    logic        rel_valid;
    logic [1:0]  rel_id;
    logic [3:0]  overrun;

    int n_cmp = 0;
    int n_err = 0;
    int hs_cnt = 0;
    int h0;

    task_release_gen dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .cfg_we      (cfg_we),
        .cfg_id      (cfg_id),
        .cfg_period  (cfg_period),
        .rel_valid   (rel_valid),
        .rel_id      (rel_id),
        .rel_ready   (rel_ready),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rel_valid && rel_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [1:0] id, input logic [15:0] per);
        cfg_we     = 1'b1;
        cfg_id     = id;
        cfg_period = per;
        step();
        cfg_we     = 1'b0;
    endtask

    initial begin
        // reset state
        step();
        step();
        chk("rst_valid", 32'(rel_valid), 0);
        chk("rst_id", 32'(rel_id), 0);
        chk("rst_ovr", 32'(overrun), 0);
        rst = 1'b1;
        en = 1'b1;
        rel_ready = 1'b1;
        step();

        // single task, period 5
        wr(2'd0, 16'd5);
        for (int k = 1; k <= 16; k++) begin
            step();
            chk("single_valid", 32'(rel_valid),
                32'((k >= 6) && (k % 5 == 1)));
            if ((k >= 6) && (k % 5 == 1))
                chk("single_id", 32'(rel_id), 0);
        end
        chk("single_ovr", 32'(overrun), 0);

        // freeze for 10 cycles mid-period
        en = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            chk("freeze_valid", 32'(rel_valid), 0);
        end
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            chk("thaw_quiet", 32'(rel_valid), 0);
        end
        step();
        chk("thaw_valid", 32'(rel_valid), 1);
        chk("thaw_id", 32'(rel_id), 0);

        // disable task 0
        wr(2'd0, 16'd0);
        for (int k = 1; k <= 12; k++) begin
            step();
            chk("disable_valid", 32'(rel_valid), 0);
        end

        // priority: tasks 0 and 2 aligned by writing while frozen
        en = 1'b0;
        wr(2'd0, 16'd4);
        wr(2'd2, 16'd4);
        en = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            step();
            chk("prio_valid", 32'(rel_valid),
                32'(j == 5 || j == 6 || j == 9 || j == 10));
            if (j == 5 || j == 6 || j == 9 || j == 10)
                chk("prio_id", 32'(rel_id), (j % 4 == 1) ? 0 : 2);
        end
        chk("prio_ovr", 32'(overrun), 0);
        en = 1'b0;
        wr(2'd0, 16'd0);
        wr(2'd2, 16'd0);
        step();
        step();

        // stall and overrun on task 1
        rel_ready = 1'b0;
        en = 1'b1;
        wr(2'd1, 16'd3);
        for (int k = 1; k <= 9; k++) begin
            step();
            chk("stall_valid", 32'(rel_valid), 32'(k >= 4));
            if (k >= 4) chk("stall_id", 32'(rel_id), 1);
            chk("stall_ovr", 32'(overrun), (k >= 9) ? 2 : 0);
        end
        en = 1'b0;
        rel_ready = 1'b1;
        h0 = hs_cnt;
        step();
        chk("drain1_valid", 32'(rel_valid), 1);
        chk("drain1_id", 32'(rel_id), 1);
        step();
        chk("drain2_valid", 32'(rel_valid), 0);
        for (int k = 1; k <= 4; k++) step();
        chk("drain_count", 32'(hs_cnt - h0), 2);
        chk("ovr_sticky", 32'(overrun), 2);
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        chk("ovr_clr", 32'(overrun), 0);

        // asynchronous reset while a release is offered
        rel_ready = 1'b0;
        en = 1'b1;
        for (int k = 1; k <= 4; k++) step();
        chk("pre_rst_valid", 32'(rel_valid), 1);
        rst = 1'b0;
        #2;
        chk("async_rst_valid", 32'(rel_valid), 0);
        chk("async_rst_id", 32'(rel_id), 0);
        step();
        rst = 1'b1;
        rel_ready = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step();
            chk("post_rst_valid", 32'(rel_valid), 0);
        end
        chk("post_rst_ovr", 32'(overrun), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/task_release_gen.md
Name: task_release_gen

Overview:
- Periodic job-release generator sitting directly upstream of the scheduler core.
- Holds one period timer per task and raises a release request each time a task's period elapses.
- Presents releases one at a time on a valid/ready port; the lowest task index has the highest priority, matching a rate-monotonic order.
- Flags overruns, i.e. a task released again while its previous release was never consumed.

Parameters:
NUM_TASKS, 4, number of periodic tasks
PERIOD_W, 16, width of a period, in clock cycles
ID_W, $clog2(NUM_TASKS), width of a task index

Ports:
clk  in  1  single system clock
rst  in  1  reset; asynchronous, active-low (asserted at 0)
en  in  1  1 = timers run; 0 = timers frozen
cfg_we  in  1  period write strobe
cfg_id  in  ID_W  task index for the write
cfg_period  in  PERIOD_W  new period; 0 disables the task
rel_valid  out  1  a release is offered
rel_id  out  ID_W  task index of the offered release
rel_ready  in  1  downstream accepts the release
overrun  out  NUM_TASKS  sticky per-task overrun flags
overrun_clr  in  1  clears all overrun flags

Behaviour:
- Reset (rst=0, async): cnt[*]=0, period[*]=0, pending[*]=0, overrun=0, slot empty, rel_valid=0, rel_id=0.
- Timer i, when en=1 and period[i]!=0:
  - if cnt[i]==period[i]-1: cnt[i]<=0 and a release event fires this cycle;
  - else cnt[i]++.
- en=0 or period[i]==0: cnt[i] holds and no event fires. The pending/slot logic keeps running.
- cfg_we=1 for task k, at the clock edge:
  - period[k]<=cfg_period, cnt[k]<=0, pending[k]<=0; overrun[k] unchanged;
  - any event of task k in that cycle is suppressed;
  - the slot is unaffected even if it holds k.
- Event for task i at an edge: pending[i]<=1.
  - If pending[i] was already 1 and is not being moved into the slot at that edge, also set overrun[i]<=1.
- Output slot: a single register, {slot_valid, slot_id}; rel_valid=slot_valid and rel_id=slot_id, both driven straight from flops.
- Slot is free when slot_valid=0, or when rel_valid&&rel_ready (the entry is consumed this edge).
  - When free and any pending bit is set: load the lowest pending index into the slot and clear that pending bit at the same edge.
  - If that same task also has an event at that edge, pending stays 1 and no overrun is set.
- Handshake: rel_id is stable while rel_valid=1 and rel_ready=0; a higher-priority arrival waits in pending.
- Back-to-back: consume and reload happen at the same edge, so with rel_ready held high one release per cycle is sustained.
- Latency: event at edge E → pending at E → rel_valid=1 after E+1, if the slot is free.
- A cfg write → first rel_valid after period+1 edges; subsequent releases are spaced exactly by the period.
- period=1: an event every cycle; pending is refilled each cycle; no overrun while rel_ready=1.
- overrun_clr=1: overrun<=0 for all tasks, except a bit set at the same edge, where the set wins.
- rst asserted mid-handshake: rel_valid drops immediately (async) and the offered release is lost.

Decomposition:
- Package sched_pkg holds:
  - NUM_TASKS, PERIOD_W and ID_W as shared localparams;
  - typedef task_id_t as logic[ID_W-1:0];
  - typedef period_t as logic[PERIOD_W-1:0];
  - typedef struct rel_req_t {valid, id}, shared with the scheduler core.
- One natural sub-module, task_timer:
  - holds the per-task counter and period register, and applies the cfg write;
  - outputs a one-cycle event strobe;
  - instantiated NUM_TASKS times with a generate loop.
- Priority encode, pending bits, slot and overrun logic stay in the top.

Test Plan:
- Single task: write period[0]=5 with en=1, rel_ready=1 → first rel_valid/rel_id=0 6 cycles after the write, then every 5 cycles, each for 1 cycle; overrun=0.
- Priority: period[0]=period[2]=4, both written in the same cycle, rel_ready=1 → rel_id=0 then rel_id=2 on consecutive cycles, every 4 cycles.
- Stall and overrun: period[1]=3 with rel_ready=0 → rel_valid held with rel_id=1 stable; after the third event overrun[1]=1.
  - Then rel_ready=1 → exactly 2 releases drain (slot plus pending).
  - Then overrun_clr → overrun=0.
- Freeze/disable: en=0 for 10 cycles mid-period → release delayed by exactly 10 cycles. Writing period[0]=0 → no further releases of task 0.
- Reset mid-operation: rst=0 while rel_valid=1 → rel_valid=0 before the next edge; after release, all periods are 0 and no rel_valid appears.
